// File: rtl/lsu_pkg.sv
// Shared types for the MEM-stage load/store unit: FSM states, access-size
// encodings and the store lane-replication helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_GNT = 2'd1,
        ST_WAIT_RV  = 2'd2,
        ST_DONE     = 2'd3
    } lsu_state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Copy the LSB-justified store operand into every lane it could land in,
    // so the memory only has to honour the shifted byte enables.
    function automatic logic [31:0] replicate_store(input logic [3:0]  size,
                                                    input logic [31:0] data);
        logic [31:0] res;
        res = data;
        if (size == BE_BYTE) begin
            res = {4{data[7:0]}};
        end else if (size == BE_HALF) begin
            res = {2{data[15:0]}};
        end
        return res;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data lane select and sign/zero extension, purely combinational.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [3:0]  size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[7:0];
        case (offset)
            2'd0: byte_lane = rdata[7:0];
            2'd1: byte_lane = rdata[15:8];
            2'd2: byte_lane = rdata[23:16];
            2'd3: byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        if (size == BE_BYTE) begin
            data = {{24{~uns & byte_lane[7]}}, byte_lane};
        end else if (size == BE_HALF) begin
            data = {{16{~uns & half_lane[15]}}, half_lane};
        end
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: req/gnt/rvalid data-memory handshake, store
// alignment, load extension and front-end stall. LSU_BUS_TIMEOUT_EN adds a bus watchdog.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_res_i,
  input  logic [31:0] rs2_fwd_i,
  input  logic [4:0]  rd_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [3:0]  byte_en_i,
  input  logic        load_uns_i,
  input  logic        reg_write_i,
  input  logic        wb_sel_mem_i,
  input  logic        adv_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_mem_o,
  output logic        misalign_o,
  output logic [31:0] alu_res_o,
  output logic [4:0]  rd_o,
  output logic        reg_write_o,
  output logic        wb_sel_mem_o,
  output logic [31:0] load_data_o,
`ifdef LSU_BUS_TIMEOUT_EN
  output logic        bus_err_o,
`endif
  output lsu_state_e  state_dbg_o
);

  // Handshake: a request is accepted on any cycle with dmem_req_o & dmem_gnt_i;
  // while waiting for gnt, req/we/addr/be/wdata stay stable and req is never
  // withdrawn. A read returns exactly one cycle with dmem_rvalid_i, at or after
  // the cycle following its grant.

  lsu_state_e  state, state_n;
  logic        acc, is_half, is_word, misalign, go;
  logic        req_c, buf_en;
  logic [31:0] load_buf, ext_data;

  assign acc      = mem_read_i | mem_write_i;
  assign is_half  = (byte_en_i == BE_HALF);
  assign is_word  = (byte_en_i == BE_WORD);
  assign misalign = acc & ((is_half & alu_res_i[0]) |
                           (is_word & (alu_res_i[1:0] != 2'b00)));
  assign go       = acc & ~misalign;

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int CNT_W = 16;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout, err_q, bus_err_q;
`endif

  always_comb begin
    state_n = state;
    req_c   = 1'b0;
    buf_en  = 1'b0;
`ifdef LSU_BUS_TIMEOUT_EN
    timeout = 1'b0;
`endif
    case (state)
      ST_IDLE, ST_WAIT_GNT: begin
        if (go) begin
          req_c = 1'b1;
          if (dmem_gnt_i) begin
            state_n = mem_write_i ? ST_DONE : ST_WAIT_RV;
          end else begin
            state_n = ST_WAIT_GNT;
          end
        end
      end
      ST_WAIT_RV: begin
        if (dmem_rvalid_i) begin
          buf_en  = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        if (adv_i) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
`ifdef LSU_BUS_TIMEOUT_EN
    // The watchdog only fires when the wait would otherwise continue.
    if (((state == ST_WAIT_GNT) || (state == ST_WAIT_RV)) && (state_n == state) &&
        (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
      timeout = 1'b1;
      state_n = ST_DONE;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      load_buf <= '0;
    end else begin
      state <= state_n;
      if (buf_en) begin
        load_buf <= ext_data;
`ifdef LSU_BUS_TIMEOUT_EN
      end else if (timeout) begin
        load_buf <= '0;
`endif
      end
    end
  end

`ifdef LSU_BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      err_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= timeout;
      if (state_n != state) begin
        wait_cnt <= '0;
      end else if ((state == ST_WAIT_GNT) || (state == ST_WAIT_RV)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout) begin
        err_q <= 1'b1;
      end else if ((state == ST_DONE) && adv_i) begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus_err_o = bus_err_q;
`endif

  lsu_load_align u_align (
    .rdata  (dmem_rdata_i),
    .offset (alu_res_i[1:0]),
    .size   (byte_en_i),
    .uns    (load_uns_i),
    .data   (ext_data)
  );

  // IDLE would otherwise raise req/stall from the held EX/MEM inputs while
  // reset is asserted; gating with rst_n drops them the moment reset hits.
  assign dmem_req_o   = req_c & rst_n;
  assign stall_mem_o  = go & (state != ST_DONE) & rst_n;
  assign dmem_we_o    = mem_write_i;
  assign dmem_addr_o  = {alu_res_i[31:2], 2'b00};
  assign dmem_be_o    = byte_en_i << alu_res_i[1:0];
  assign dmem_wdata_o = replicate_store(byte_en_i, rs2_fwd_i);
  assign misalign_o   = misalign;

  assign alu_res_o    = alu_res_i;
  assign rd_o         = rd_i;
  assign wb_sel_mem_o = wb_sel_mem_i;
`ifdef LSU_BUS_TIMEOUT_EN
  assign reg_write_o  = reg_write_i & ~misalign & ~err_q;
`else
  assign reg_write_o  = reg_write_i & ~misalign;
`endif
  assign load_data_o  = load_buf;
  assign state_dbg_o  = state;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: driver tasks, a bus responder, and two
// scoreboards (write-back handoff and bus acceptance) popped by monitors.
module tb_mem_lsu;
  import lsu_pkg::*;

  logic        clk, rst_n;
  logic [31:0] alu_res_i, rs2_fwd_i;
  logic [4:0]  rd_i;
  logic        mem_read_i, mem_write_i;
  logic [3:0]  byte_en_i;
  logic        load_uns_i, reg_write_i, wb_sel_mem_i, adv_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_mem_o, misalign_o;
  logic [31:0] alu_res_o;
  logic [4:0]  rd_o;
  logic        reg_write_o, wb_sel_mem_o;
  logic [31:0] load_data_o;
  lsu_state_e  state_dbg_o;
`ifdef LSU_BUS_TIMEOUT_EN
  logic        bus_err;
`endif

  int total = 0;
  int bad   = 0;

  int          gnt_delay = 0;
  logic [31:0] rdata_val = '0;

  logic [39:0] exp_q[$];
  logic [68:0] bus_q[$];

  mem_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_res_i    (alu_res_i),
    .rs2_fwd_i    (rs2_fwd_i),
    .rd_i         (rd_i),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .byte_en_i    (byte_en_i),
    .load_uns_i   (load_uns_i),
    .reg_write_i  (reg_write_i),
    .wb_sel_mem_i (wb_sel_mem_i),
    .adv_i        (adv_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_gnt_i   (dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i (dmem_rdata_i),
    .stall_mem_o  (stall_mem_o),
    .misalign_o   (misalign_o),
    .alu_res_o    (alu_res_o),
    .rd_o         (rd_o),
    .reg_write_o  (reg_write_o),
    .wb_sel_mem_o (wb_sel_mem_o),
    .load_data_o  (load_data_o),
`ifdef LSU_BUS_TIMEOUT_EN
    .bus_err_o    (bus_err),
`endif
    .state_dbg_o  (state_dbg_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog act=running exp=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // bus responder: grants after gnt_delay request cycles, read data one cycle later
  initial begin
    int   wait_ctr;
    logic rv_next;
    wait_ctr = 0;
    rv_next  = 1'b0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = '0;
    forever begin
      @(posedge clk);
      #2;
      dmem_rvalid_i = rv_next;
      dmem_rdata_i  = rv_next ? rdata_val : 32'h0;
      rv_next = 1'b0;
      if (dmem_req_o) begin
        if (wait_ctr >= gnt_delay) begin
          dmem_gnt_i = 1'b1;
          wait_ctr   = 0;
          rv_next    = !dmem_we_o;
        end else begin
          dmem_gnt_i = 1'b0;
          wait_ctr++;
        end
      end else begin
        dmem_gnt_i = 1'b0;
        wait_ctr   = 0;
      end
    end
  end

  // handoff monitor: the MEM/WB register captures here
  initial begin
    logic [39:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && (mem_read_i || mem_write_i) && !stall_mem_o && adv_i) begin
        if (exp_q.size() == 0) begin
          check("wb_underflow", 72'(1), 72'(0));
        end else begin
          e = exp_q.pop_front();
          check("wb_load_data", 72'(load_data_o), 72'(e[39:8]));
          check("wb_rd",        72'(rd_o),        72'(e[7:3]));
          check("wb_reg_write", 72'(reg_write_o), 72'(e[2]));
          check("wb_sel_mem",   72'(wb_sel_mem_o), 72'(e[1]));
          check("wb_misalign",  72'(misalign_o),  72'(e[0]));
        end
      end
    end
  end

  // bus monitor: every accepted request
  initial begin
    logic [68:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && dmem_req_o && dmem_gnt_i) begin
        if (bus_q.size() == 0) begin
          check("bus_underflow", 72'(1), 72'(0));
        end else begin
          e = bus_q.pop_front();
          check("bus_we",    72'(dmem_we_o),    72'(e[68]));
          check("bus_addr",  72'(dmem_addr_o),  72'(e[67:36]));
          check("bus_be",    72'(dmem_be_o),    72'(e[35:32]));
          check("bus_wdata", 72'(dmem_wdata_o), 72'(e[31:0]));
        end
      end
    end
  end

  task automatic clear_inputs();
    mem_read_i   = 1'b0;
    mem_write_i  = 1'b0;
    reg_write_i  = 1'b0;
    wb_sel_mem_i = 1'b0;
    load_uns_i   = 1'b0;
    adv_i        = 1'b1;
    rs2_fwd_i    = '0;
    byte_en_i    = BE_WORD;
  endtask

  task automatic run_access(input logic is_ld, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] size,
                            input logic uns, input logic [4:0] rd,
                            input int gdly, input logic [31:0] rdata, input int hold,
                            input int exp_stall, input int exp_req, input logic exp_mis,
                            input logic [31:0] exp_load, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
    int   stall_cnt, req_cnt, h;
    logic done;
    @(posedge clk);
    #1;
    gnt_delay    = gdly;
    rdata_val    = rdata;
    alu_res_i    = addr;
    rs2_fwd_i    = data;
    rd_i         = rd;
    mem_read_i   = is_ld;
    mem_write_i  = !is_ld;
    byte_en_i    = size;
    load_uns_i   = uns;
    reg_write_i  = is_ld;
    wb_sel_mem_i = is_ld;
    adv_i        = (hold == 0);
    exp_q.push_back({exp_load, rd, is_ld & ~exp_mis, is_ld, exp_mis});
    if (!exp_mis) bus_q.push_back({!is_ld, addr & 32'hFFFF_FFFC, exp_be, exp_wdata});
    stall_cnt = 0;
    req_cnt   = 0;
    h         = hold;
    done      = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (stall_mem_o) stall_cnt++;
      if (dmem_req_o)  req_cnt++;
      if (!stall_mem_o) begin
        if (adv_i) begin
          done = 1'b1;
        end else begin
          check("hold_state", 72'(state_dbg_o), 72'(ST_DONE));
          check("hold_data",  72'(load_data_o), 72'(exp_load));
          h--;
          if (h <= 0) begin
            @(posedge clk);
            #1;
            adv_i = 1'b1;
          end
        end
      end
    end
    if (!done) check("handoff_timeout", 72'(0), 72'(1));
    check("stall_cycles", 72'(stall_cnt), 72'(exp_stall));
    check("req_cycles",   72'(req_cnt),   72'(exp_req));
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  initial begin
    rst_n     = 1'b0;
    alu_res_i = '0;
    rd_i      = '0;
    clear_inputs();
    repeat (3) @(negedge clk);
    check("rst_req",   72'(dmem_req_o),  72'(0));
    check("rst_stall", 72'(stall_mem_o), 72'(0));
    check("rst_data",  72'(load_data_o), 72'(0));
    check("rst_state", 72'(state_dbg_o), 72'(ST_IDLE));
    rst_n = 1'b1;

    //          ld    addr          data          size     uns  rd  gd rdata         hold st rq mis load          be       wdata
    run_access(1'b1, 32'h0000_0100, 32'h0,        BE_WORD, 1'b0, 5, 0, 32'hDEADBEEF, 0, 2, 1, 0, 32'hDEADBEEF, 4'b1111, 32'h0);
    run_access(1'b1, 32'h0000_0103, 32'h0,        BE_BYTE, 1'b0, 6, 0, 32'h80112233, 0, 2, 1, 0, 32'hFFFFFF80, 4'b1000, 32'h0);
    run_access(1'b1, 32'h0000_0103, 32'h0,        BE_BYTE, 1'b1, 7, 0, 32'h80112233, 0, 2, 1, 0, 32'h00000080, 4'b1000, 32'h0);
    run_access(1'b1, 32'h0000_0102, 32'h0,        BE_HALF, 1'b0, 8, 1, 32'h80112233, 0, 3, 2, 0, 32'hFFFF8011, 4'b1100, 32'h0);
    run_access(1'b1, 32'h0000_0100, 32'h0,        BE_HALF, 1'b1, 9, 0, 32'h80112233, 0, 2, 1, 0, 32'h00002233, 4'b0011, 32'h0);
    run_access(1'b1, 32'h0000_0101, 32'h0,        BE_BYTE, 1'b0, 10, 0, 32'h80112233, 0, 2, 1, 0, 32'h00000022, 4'b0010, 32'h0);
    run_access(1'b0, 32'h0000_0202, 32'h0000ABCD, BE_HALF, 1'b0, 11, 3, 32'h0,       0, 4, 4, 0, 32'h00000022, 4'b1100, 32'hABCDABCD);
    run_access(1'b0, 32'h0000_0001, 32'h12345677, BE_BYTE, 1'b0, 12, 0, 32'h0,       0, 1, 1, 0, 32'h00000022, 4'b0010, 32'h77777777);
    run_access(1'b0, 32'h0000_0300, 32'hCAFEF00D, BE_WORD, 1'b0, 13, 1, 32'h0,       0, 2, 2, 0, 32'h00000022, 4'b1111, 32'hCAFEF00D);
    run_access(1'b1, 32'h0000_0101, 32'h0,        BE_WORD, 1'b0, 14, 0, 32'h0,       0, 0, 0, 1, 32'h00000022, 4'b0000, 32'h0);
    run_access(1'b0, 32'h0000_0203, 32'h0000BEEF, BE_HALF, 1'b0, 15, 0, 32'h0,       0, 0, 0, 1, 32'h00000022, 4'b0000, 32'h0);
    run_access(1'b1, 32'h0000_0104, 32'h0,        BE_WORD, 1'b0, 16, 0, 32'h01234567, 2, 2, 1, 0, 32'h01234567, 4'b1111, 32'h0);
    run_access(1'b1, 32'h0000_0108, 32'h0,        BE_WORD, 1'b0, 17, 2, 32'h7F00FF00, 0, 4, 3, 0, 32'h7F00FF00, 4'b1111, 32'h0);

    // reset in the middle of a stalled request
    @(posedge clk);
    #1;
    gnt_delay   = 100;
    alu_res_i   = 32'h0000_0400;
    mem_read_i  = 1'b1;
    reg_write_i = 1'b1;
    byte_en_i   = BE_WORD;
    repeat (2) @(negedge clk);
    check("midrst_req_before",   72'(dmem_req_o),  72'(1));
    check("midrst_state_before", 72'(state_dbg_o), 72'(ST_WAIT_GNT));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_req",   72'(dmem_req_o),  72'(0));
    check("midrst_stall", 72'(stall_mem_o), 72'(0));
    check("midrst_state", 72'(state_dbg_o), 72'(ST_IDLE));
    clear_inputs();
    @(negedge clk);
    rst_n     = 1'b1;
    gnt_delay = 0;

`ifdef LSU_BUS_TIMEOUT_EN
    begin
      int req_cnt;
      @(posedge clk);
      #1;
      gnt_delay    = 1000;
      alu_res_i    = 32'h0000_0500;
      mem_read_i   = 1'b1;
      reg_write_i  = 1'b1;
      wb_sel_mem_i = 1'b1;
      byte_en_i    = BE_WORD;
      adv_i        = 1'b0;
      req_cnt      = 0;
      for (int c = 0; c < 20 && stall_mem_o !== 1'b0; c++) begin
        @(negedge clk);
        if (dmem_req_o) req_cnt++;
        if (stall_mem_o) check("to_no_err_yet", 72'(bus_err), 72'(0));
      end
      check("to_req_cycles", 72'(req_cnt),     72'(5));
      check("to_bus_err",    72'(bus_err),     72'(1));
      check("to_req_drop",   72'(dmem_req_o),  72'(0));
      check("to_load_zero",  72'(load_data_o), 72'(0));
      check("to_reg_write",  72'(reg_write_o), 72'(0));
      @(negedge clk);
      check("to_err_pulse",  72'(bus_err),     72'(0));
      @(posedge clk);
      #1;
      clear_inputs();
      gnt_delay = 0;
      @(negedge clk);
      check("to_back_idle",  72'(state_dbg_o), 72'(ST_IDLE));
    end
`endif

    repeat (2) @(negedge clk);
    check("wb_queue_empty",  72'(exp_q.size()), 72'(0));
    check("bus_queue_empty", 72'(bus_q.size()), 72'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
